msg_feeder: RTL and testbench
=============================

MSG_FEEDER -- requirements
Module: msg_feeder

Upstream character source for the letter-dial printer. It buffers ASCII characters and hands them one at a time to the printer over a req/ready handshake.

Interface
REQ-001 The block SHALL have exactly one clock; reset is synchronous and active-high.
REQ-002 sys_clk  in  1  system clock; all state changes on its rising edge.
REQ-003 reset  in  1  synchronous active-high reset.
REQ-004 wr_en  in  1  write strobe; one character offered per cycle.
REQ-005 wr_data  in  7  ASCII character offered with wr_en.
REQ-006 ready  in  1  printer idle / able to accept (1) or printing (0).
REQ-007 req  out  1  one-cycle request to the printer; ascii_out is valid while it is high.
REQ-008 ascii_out  out  7  registered character presented to the printer.
REQ-009 full  out  1  FIFO holds 8 entries.
REQ-010 empty  out  1  FIFO holds 0 entries.
REQ-011 count  out  4  FIFO occupancy, 0..8.
REQ-012 bad_char  out  1  one-cycle pulse: an illegal character was dropped.
REQ-013 ovf  out  1  one-cycle pulse: a write was dropped because the FIFO was full.
REQ-014 busy  out  1  high whenever the FSM is not in IDLE.

Function
REQ-015 The FIFO SHALL be 8 entries x 7 bits, first-in first-out, with 3-bit read and write pointers that wrap 7->0.
REQ-016 Legal characters SHALL be 7'h20 (space), 7'h61-7'h7A (a-z), 7'h2C (comma), 7'h2E (period) and 7'h3F (question mark).
REQ-017 A write SHALL be accepted when wr_en=1, the character is legal and full=0; full is taken from the pre-edge value.
REQ-018 A write with wr_en=1 and an illegal character SHALL be dropped and bad_char SHALL pulse in the next cycle; the illegal check takes priority over ovf.
REQ-019 A write with wr_en=1, a legal character and full=1 SHALL be dropped and ovf SHALL pulse in the next cycle, even if a pop occurs in the same cycle.
REQ-020 count SHALL update as follows:
- +1 on an accepted write;
- -1 on a pop;
- unchanged when both occur in the same cycle.
full and empty SHALL be decoded from count.
REQ-021 The FSM SHALL have states IDLE, REQ, WAIT_BUSY and WAIT_DONE.
REQ-022 IDLE: if empty=0 and ready=1, pop the head entry into ascii_out and go to REQ; otherwise stay in IDLE.
REQ-023 REQ: req=1 for exactly this cycle; go to WAIT_BUSY and clear the 4-bit timeout counter.
REQ-024 WAIT_BUSY: if ready=0, go to WAIT_DONE; otherwise increment the timer, and when the timer reaches 15 return to REQ (retry with the same ascii_out, no pop).
REQ-025 WAIT_DONE: if ready=1, go to IDLE; otherwise stay.
REQ-026 ascii_out SHALL change only on a pop and SHALL hold its value through REQ, WAIT_BUSY and WAIT_DONE.
REQ-027 req SHALL be 0 in every state other than REQ.
REQ-028 Latency: a legal character written at edge t into an empty FIFO, with the FSM in IDLE and ready=1, SHALL be popped at edge t+1, with req high in the cycle following edge t+1.
REQ-029 Writes SHALL continue to be accepted while the FSM is in any state.

Reset
REQ-030 On reset=1 at a clock edge, the block SHALL:
- set state to IDLE;
- reset both pointers and count to 0, and the timer to 0;
- drive req=0, ascii_out=7'h20, empty=1, full=0, bad_char=0, ovf=0, busy=0.
REQ-031 Reset SHALL override a simultaneous write or pop; any queued or in-flight character is discarded.
REQ-032 Reset asserted during WAIT_BUSY or WAIT_DONE SHALL return the FSM to IDLE on the same edge, with req=0 the following cycle.

Verification
REQ-033 Single character:
- stimulus: write 7'h61 with ready=1; printer model drops ready 2 cycles after req and raises it 10 cycles later;
- required: req pulses once with ascii_out=7'h61, and busy returns to 0 one cycle after ready rises.
REQ-034 Ordering:
- stimulus: write "hi." (7'h68, 7'h69, 7'h2E) back-to-back;
- required: three req pulses in that order, count peaks at 3 (or 2 if the first pop has already occurred), and the FIFO ends empty.
REQ-035 Overflow and illegal characters:
- stimulus: hold ready=0 and write 10 legal characters;
- required: count=8, full=1, ovf pulses twice;
- stimulus: then write 7'h41 ('A');
- required: bad_char pulses and count stays 8.
REQ-036 Timeout retry:
- stimulus: ready stays 1 after req;
- required: req re-pulses 16 cycles after the first req with the same ascii_out, and count is not decremented.
REQ-037 Reset mid-operation:
- stimulus: 4 characters queued, FSM in WAIT_DONE, assert reset for 1 cycle;
- required: count=0, empty=1, req=0, ascii_out=7'h20, busy=0; a later write of 7'h62 is delivered normally.

Source files
------------

// File: rtl/msg_feeder.sv
// Character feeder for the letter-dial printer: an 8-deep ASCII FIFO that
// filters illegal characters and hands entries to the printer over req/ready.
module msg_feeder (
  input  logic       sys_clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [6:0] wr_data,
  input  logic       ready,
  output logic       req,
  output logic [6:0] ascii_out,
  output logic       full,
  output logic       empty,
  output logic [3:0] count,
  output logic       bad_char,
  output logic       ovf,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_BUSY, WAIT_DONE} state_t;

  state_t     state;
  logic [6:0] mem [8];
  logic [2:0] wptr, rptr;
  logic [3:0] timer;
  logic       legal, wr_acc, pop;

  always_comb begin
    legal = (wr_data == 7'h20) || (wr_data == 7'h2C) || (wr_data == 7'h2E) ||
            (wr_data == 7'h3F) || ((wr_data >= 7'h61) && (wr_data <= 7'h7A));
  end

  assign full   = (count == 4'd8);
  assign empty  = (count == 4'd0);
  assign wr_acc = wr_en && legal && !full;
  assign pop    = (state == IDLE) && !empty && ready;

  // Storage carries no reset; validity is tracked entirely by the pointers/count.
  always_ff @(posedge sys_clk) begin
    if (wr_acc && !reset) mem[wptr] <= wr_data;
  end

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state     <= IDLE;
      wptr      <= 3'd0;
      rptr      <= 3'd0;
      count     <= 4'd0;
      timer     <= 4'd0;
      req       <= 1'b0;
      ascii_out <= 7'h20;
      bad_char  <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
    end else begin
      bad_char <= wr_en && !legal;
      ovf      <= wr_en && legal && full;
      if (wr_acc) wptr <= wptr + 3'd1;
      if (pop)    rptr <= rptr + 3'd1;
      case ({wr_acc, pop})
        2'b10:   count <= count + 4'd1;
        2'b01:   count <= count - 4'd1;
        default: ;
      endcase

      // req is registered on entry to REQ so it is high exactly while in REQ
      req <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            ascii_out <= mem[rptr];
            state     <= REQ;
            req       <= 1'b1;
            busy      <= 1'b1;
          end
        end
        REQ: begin
          state <= WAIT_BUSY;
          timer <= 4'd0;
        end
        WAIT_BUSY: begin
          if (!ready) begin
            state <= WAIT_DONE;
          end else begin
            timer <= timer + 4'd1;
            // timer about to reach 15: retry the same character
            if (timer == 4'd14) begin
              state <= REQ;
              req   <= 1'b1;
            end
          end
        end
        WAIT_DONE: begin
          if (ready) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msg_feeder.sv
// Directed bench for msg_feeder: single char, ordering, overflow/illegal,
// timeout retry and mid-operation reset.
module tb_msg_feeder;

  logic       sys_clk = 1'b0;
  logic       reset, wr_en, ready;
  logic [6:0] wr_data;
  logic       req, full, empty, bad_char, ovf, busy;
  logic [6:0] ascii_out;
  logic [3:0] count;

  int tests = 0;
  int fails = 0;

  msg_feeder dut (
    .sys_clk  (sys_clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .ready    (ready),
    .req      (req),
    .ascii_out(ascii_out),
    .full     (full),
    .empty    (empty),
    .count    (count),
    .bad_char (bad_char),
    .ovf      (ovf),
    .busy     (busy)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called just after the edge that entered REQ; leaves FSM in IDLE with ready=1.
  task automatic serve();
    ready = 1'b0;
    step();
    step();
    ready = 1'b1;
    step();
  endtask

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_data = 7'h00; ready = 1'b1;
    step(); step();
    reset = 1'b0;
    chk("rst_req", {7'd0, req}, 8'h00);
    chk("rst_ascii", {1'b0, ascii_out}, 8'h20);
    chk("rst_empty", {7'd0, empty}, 8'h01);
    chk("rst_full", {7'd0, full}, 8'h00);
    chk("rst_count", {4'd0, count}, 8'h00);
    chk("rst_bad", {7'd0, bad_char}, 8'h00);
    chk("rst_ovf", {7'd0, ovf}, 8'h00);
    chk("rst_busy", {7'd0, busy}, 8'h00);

    // single character, latency and busy release
    wr_en = 1'b1; wr_data = 7'h61;
    step();
    wr_en = 1'b0;
    chk("one_count", {4'd0, count}, 8'h01);
    chk("one_empty", {7'd0, empty}, 8'h00);
    chk("one_req_early", {7'd0, req}, 8'h00);
    step();
    chk("one_req", {7'd0, req}, 8'h01);
    chk("one_ascii", {1'b0, ascii_out}, 8'h61);
    chk("one_busy", {7'd0, busy}, 8'h01);
    chk("one_popcnt", {4'd0, count}, 8'h00);
    step();
    chk("one_req_drop", {7'd0, req}, 8'h00);
    ready = 1'b0;
    for (int i = 0; i < 11; i++) step();
    chk("one_busy_hold", {7'd0, busy}, 8'h01);
    chk("one_req_once", {7'd0, req}, 8'h00);
    chk("one_ascii_hold", {1'b0, ascii_out}, 8'h61);
    ready = 1'b1;
    step();
    chk("one_busy_rel", {7'd0, busy}, 8'h00);

    // ordering "hi."
    wr_en = 1'b1; wr_data = 7'h68;
    step();
    chk("ord_cnt1", {4'd0, count}, 8'h01);
    wr_data = 7'h69;
    step();
    chk("ord_req_h", {7'd0, req}, 8'h01);
    chk("ord_ascii_h", {1'b0, ascii_out}, 8'h68);
    chk("ord_cnt_h", {4'd0, count}, 8'h01);
    wr_data = 7'h2E; ready = 1'b0;
    step();
    wr_en = 1'b0;
    chk("ord_peak", {4'd0, count}, 8'h02);
    step();
    ready = 1'b1;
    step();
    step();
    chk("ord_req_i", {7'd0, req}, 8'h01);
    chk("ord_ascii_i", {1'b0, ascii_out}, 8'h69);
    chk("ord_cnt_i", {4'd0, count}, 8'h01);
    serve();
    step();
    chk("ord_req_p", {7'd0, req}, 8'h01);
    chk("ord_ascii_p", {1'b0, ascii_out}, 8'h2E);
    chk("ord_empty", {7'd0, empty}, 8'h01);
    serve();
    chk("ord_idle", {7'd0, busy}, 8'h00);

    // overflow and illegal characters
    ready = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      wr_data = 7'h61 + 7'(i);
      step();
      if (i == 7) begin
        chk("ovf_cnt8", {4'd0, count}, 8'h08);
        chk("ovf_full", {7'd0, full}, 8'h01);
        chk("ovf_none", {7'd0, ovf}, 8'h00);
      end
      if (i >= 8) begin
        chk("ovf_pulse", {7'd0, ovf}, 8'h01);
        chk("ovf_cnt", {4'd0, count}, 8'h08);
      end
    end
    wr_data = 7'h41;
    step();
    chk("bad_pulse", {7'd0, bad_char}, 8'h01);
    chk("bad_no_ovf", {7'd0, ovf}, 8'h00);
    chk("bad_cnt", {4'd0, count}, 8'h08);
    wr_en = 1'b0;
    step();
    chk("bad_clear", {7'd0, bad_char}, 8'h00);
    // full write coincident with a pop: still dropped
    wr_en = 1'b1; wr_data = 7'h7A; ready = 1'b1;
    step();
    wr_en = 1'b0;
    chk("ovfpop_ovf", {7'd0, ovf}, 8'h01);
    chk("ovfpop_cnt", {4'd0, count}, 8'h07);
    chk("ovfpop_req", {7'd0, req}, 8'h01);
    chk("ovfpop_ascii", {1'b0, ascii_out}, 8'h61);

    // timeout retry: ready stays high
    for (int i = 0; i < 15; i++) step();
    chk("to_req_low", {7'd0, req}, 8'h00);
    chk("to_busy", {7'd0, busy}, 8'h01);
    step();
    chk("to_req_retry", {7'd0, req}, 8'h01);
    chk("to_ascii", {1'b0, ascii_out}, 8'h61);
    chk("to_cnt", {4'd0, count}, 8'h07);

    // reset mid-operation
    reset = 1'b1;
    step();
    reset = 1'b0; ready = 1'b0; wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wr_data = 7'h6B + 7'(i);
      step();
    end
    wr_en = 1'b0;
    chk("mr_cnt5", {4'd0, count}, 8'h05);
    ready = 1'b1;
    step();
    ready = 1'b0;
    step();
    step();
    chk("mr_cnt4", {4'd0, count}, 8'h04);
    chk("mr_busy", {7'd0, busy}, 8'h01);
    chk("mr_ascii_k", {1'b0, ascii_out}, 8'h6B);
    reset = 1'b1; wr_en = 1'b1; wr_data = 7'h63; ready = 1'b1;
    step();
    reset = 1'b0; wr_en = 1'b0;
    chk("mr_count", {4'd0, count}, 8'h00);
    chk("mr_empty", {7'd0, empty}, 8'h01);
    chk("mr_req", {7'd0, req}, 8'h00);
    chk("mr_ascii", {1'b0, ascii_out}, 8'h20);
    chk("mr_busy0", {7'd0, busy}, 8'h00);
    wr_en = 1'b1; wr_data = 7'h62;
    step();
    wr_en = 1'b0;
    step();
    chk("mr_req_b", {7'd0, req}, 8'h01);
    chk("mr_ascii_b", {1'b0, ascii_out}, 8'h62);
    chk("mr_cnt_b", {4'd0, count}, 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
